// File: rtl/frame_tx_pkg.sv
// rtl/frame_tx_pkg.sv - shared types and default timing for the frame replay transmitter
package frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_TOTAL  = 525;
    localparam int PIX_W        = 10;
    localparam int CNT_W        = 10;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - slot divider and H/V raster counters producing the pixel clock
module raster_counter
    import frame_tx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int CLK_DIV  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic             o_pixclk,
    output logic             o_slot_end,
    output logic             o_frame_end,
    output logic             o_next_active,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW1   = CNT_W + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CW1-1:0]   H_ACT_W  = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0]   V_ACT_W  = CW1'(V_ACTIVE);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_pixclk;

    logic             w_div_last;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_line_end;
    logic [DIV_W-1:0] w_div_next;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;

    assign w_div_last = (r_div == DIV_LAST);
    assign w_h_last   = (r_h == H_LAST);
    assign w_v_last   = (r_v == V_LAST);
    assign w_div_next = w_div_last ? '0 : r_div + 1'b1;
    assign w_h_next   = w_h_last ? '0 : r_h + 1'b1;
    assign w_v_next   = w_h_last ? (w_v_last ? '0 : r_v + 1'b1) : r_v;

    assign o_slot_end    = i_en && w_div_last;
    assign w_line_end    = o_slot_end && w_h_last;
    assign o_frame_end   = w_line_end && w_v_last;
    // Active flag of the slot that begins after the current one ends
    assign o_next_active = ({1'b0, w_h_next} < H_ACT_W) && ({1'b0, w_v_next} < V_ACT_W);

    assign o_pixclk = r_pixclk;
    assign o_h      = r_h;
    assign o_v      = r_v;

    // Divider and counters advance only while running; a frame end wraps everything to zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div    <= '0;
            r_h      <= '0;
            r_v      <= '0;
            r_pixclk <= 1'b0;
        end else if (i_en) begin
            r_div    <= w_div_next;
            r_pixclk <= (w_div_next >= DIV_HALF);
            if (w_div_last) begin
                r_h <= w_h_next;
                r_v <= w_v_next;
            end
        end
    end

endmodule

// File: rtl/frame_replay_tx.sv
// rtl/frame_replay_tx.sv - replays a stored frame as a camera-style raster pixel stream
module frame_replay_tx
    import frame_tx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int CLK_DIV  = 2,
    parameter int ADDR_W   = 19
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              loop,
    input  logic              cansend,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pixclk,
    output logic [CNT_W-1:0]  H_Cont,
    output logic [CNT_W-1:0]  V_Cont,
    output logic [PIX_W-1:0]  pixval,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    tx_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]  r_pixval;
    logic              r_busy;
    logic              r_done;

    logic w_slot_end;
    logic w_frame_end;
    logic w_next_active;

    // Address of the active pixel following a, wrapping to 0 after the last one
    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .CLK_DIV  (CLK_DIV)
    ) u_raster (
        .i_clk         (CLK),
        .i_rst_n       (RESET),
        .i_en          (r_state == ST_RUN),
        .o_pixclk      (pixclk),
        .o_slot_end    (w_slot_end),
        .o_frame_end   (w_frame_end),
        .o_next_active (w_next_active),
        .o_h           (H_Cont),
        .o_v           (V_Cont)
    );

    assign pix_addr   = r_addr;
    assign pixval     = r_pixval;
    assign busy       = r_busy;
    assign frame_done = r_done;

    // Frame FSM: the store word fetched during a slot becomes pixval at the next slot boundary
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_pixval <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && cansend) begin
                        r_state <= ST_PRIME;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    // Address 0 has been presented since idle, so its word is already valid
                    r_state  <= ST_RUN;
                    r_pixval <= pix_data;
                    r_addr   <= f_next_addr(r_addr);
                end
                ST_RUN: begin
                    if (w_frame_end) begin
                        r_done <= 1'b1;
                    end
                    if (w_frame_end && !(loop && cansend)) begin
                        r_state  <= ST_IDLE;
                        r_pixval <= '0;
                    end else if (w_slot_end) begin
                        if (w_next_active) begin
                            r_pixval <= pix_data;
                            r_addr   <= f_next_addr(r_addr);
                        end else begin
                            r_pixval <= '0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_replay_tx.sv
// tb/tb_frame_replay_tx.sv - self-checking bench for frame_replay_tx
module tb_frame_replay_tx;

    localparam int H_ACTIVE  = 4;
    localparam int H_TOTAL   = 6;
    localparam int V_ACTIVE  = 3;
    localparam int V_TOTAL   = 4;
    localparam int CLK_DIV   = 2;
    localparam int ADDR_W    = 19;
    localparam int FRAME_CYC = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam int N_ACT     = H_ACTIVE * V_ACTIVE;

    logic              clk = 1'b0;
    logic              RESET;
    logic              start;
    logic              loop;
    logic              cansend;
    logic [ADDR_W-1:0] pix_addr;
    logic [9:0]        pix_data;
    logic              pixclk;
    logic [9:0]        H_Cont;
    logic [9:0]        V_Cont;
    logic [9:0]        pixval;
    logic              busy;
    logic              frame_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [9:0] prev_h, prev_v, prev_pix;
    bit   exp_loop;

    typedef struct { int rel; int h; int v; int pix; int pclk; } land_t;
    typedef struct { bit st; bit cs; int cycles; int exp_busy; } gate_t;
    land_t land[9];
    gate_t gates[4];

    frame_replay_tx #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .CLK_DIV  (CLK_DIV),
        .ADDR_W   (ADDR_W)
    ) dut (
        .CLK        (clk),
        .RESET      (RESET),
        .start      (start),
        .loop       (loop),
        .cansend    (cansend),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .pixclk     (pixclk),
        .H_Cont     (H_Cont),
        .V_Cont     (V_Cont),
        .pixval     (pixval),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Frame store model: word = address + 100, one cycle read latency
    always @(posedge clk) pix_data <= 10'(pix_addr) + 10'd100;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pixclk"}, 32'(pixclk), 0);
        chk({tag, "_h"}, 32'(H_Cont), 0);
        chk({tag, "_v"}, 32'(V_Cont), 0);
        chk({tag, "_pixval"}, 32'(pixval), 0);
        chk({tag, "_addr"}, 32'(pix_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
    endtask

    // Reference: position of cycle rel within a frame derived from plain slot arithmetic
    task automatic check_model(input int rel, input bit looped_in, input bit use_land);
        int k, h, v, pix, pclk, n;
        k    = rel / CLK_DIV;
        h    = k % H_TOTAL;
        v    = k / H_TOTAL;
        pix  = (h < H_ACTIVE && v < V_ACTIVE) ? v * H_ACTIVE + h + 100 : 0;
        pclk = ((rel % CLK_DIV) >= CLK_DIV / 2) ? 1 : 0;
        n    = ((v < V_ACTIVE) ? v : V_ACTIVE) * H_ACTIVE
             + ((v < V_ACTIVE) ? ((h + 1 < H_ACTIVE) ? h + 1 : H_ACTIVE) : 0);
        chk("run_h", 32'(H_Cont), h);
        chk("run_v", 32'(V_Cont), v);
        chk("run_pixval", 32'(pixval), pix);
        chk("run_pixclk", 32'(pixclk), pclk);
        chk("run_addr", 32'(pix_addr), n % N_ACT);
        chk("run_busy", 32'(busy), 1);
        chk("run_done", 32'(frame_done), (rel == 0 && looped_in) ? 1 : 0);
        if (pixclk === 1'b1) begin
            chk("stable_h", 32'(H_Cont), int'(prev_h));
            chk("stable_v", 32'(V_Cont), int'(prev_v));
            chk("stable_pix", 32'(pixval), int'(prev_pix));
        end
        prev_h   = H_Cont;
        prev_v   = V_Cont;
        prev_pix = pixval;
        if (use_land) begin
            foreach (land[i]) begin
                if (land[i].rel == rel) begin
                    chk("land_h", 32'(H_Cont), land[i].h);
                    chk("land_v", 32'(V_Cont), land[i].v);
                    chk("land_pix", 32'(pixval), land[i].pix);
                    chk("land_pclk", 32'(pixclk), land[i].pclk);
                end
            end
        end
    endtask

    // Runs one frame from its PRIME cycle (first=1) or from slot (0,0) of a looped frame
    task automatic run_frame(input bit first, input bit looped_in, input bit rnd,
                             input int drop_rel, input bit allow_loop, input bit use_land,
                             output bit looped_out);
        if (first) begin
            chk("prime_busy", 32'(busy), 1);
            chk("prime_addr", 32'(pix_addr), 0);
            chk("prime_pclk", 32'(pixclk), 0);
            chk("prime_h", 32'(H_Cont), 0);
            chk("prime_pix", 32'(pixval), 0);
            tick();
        end
        for (int rel = 0; rel < FRAME_CYC; rel++) begin
            check_model(rel, looped_in, use_land);
            if (rnd) begin
                start   = 1'($urandom % 2);
                cansend = 1'($urandom % 2);
            end
            if (rel == drop_rel) cansend = 1'b0;
            if (rel == FRAME_CYC - 1) begin
                start = 1'b0;
                if (!allow_loop) cansend = 1'b0;
            end
            exp_loop = loop && cansend;
            tick();
        end
        looped_out = exp_loop;
        if (!exp_loop) begin
            chk("end_done", 32'(frame_done), 1);
            chk("end_busy", 32'(busy), 1);
            chk("end_pixclk", 32'(pixclk), 0);
            chk("end_h", 32'(H_Cont), 0);
            chk("end_v", 32'(V_Cont), 0);
            chk("end_pixval", 32'(pixval), 0);
            chk("end_addr", 32'(pix_addr), 0);
            tick();
            chk("post_busy", 32'(busy), 0);
            chk("post_done", 32'(frame_done), 0);
        end
    endtask

    initial begin
        bit lo;
        int nfr;
        land[0] = '{0, 0, 0, 100, 0};
        land[1] = '{1, 0, 0, 100, 1};
        land[2] = '{2, 1, 0, 101, 0};
        land[3] = '{8, 4, 0, 0, 0};
        land[4] = '{12, 0, 1, 104, 0};
        land[5] = '{30, 3, 2, 111, 0};
        land[6] = '{31, 3, 2, 111, 1};
        land[7] = '{36, 0, 3, 0, 0};
        land[8] = '{47, 5, 3, 0, 1};
        gates[0] = '{1'b1, 1'b0, 100, 0};
        gates[1] = '{1'b0, 1'b1, 5, 0};
        gates[2] = '{1'b0, 1'b0, 5, 0};
        gates[3] = '{1'b1, 1'b1, 1, 1};

        RESET = 1'b0; start = 1'b0; loop = 1'b0; cansend = 1'b0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        RESET = 1'b1;
        tick();

        // Start gating table; the final entry launches a single frame
        foreach (gates[i]) begin
            start   = gates[i].st;
            cansend = gates[i].cs;
            for (int c = 0; c < gates[i].cycles; c++) begin
                tick();
                chk("gate_busy", 32'(busy), gates[i].exp_busy);
                if (gates[i].exp_busy == 0) begin
                    chk("gate_pixclk", 32'(pixclk), 0);
                    chk("gate_addr", 32'(pix_addr), 0);
                end
            end
        end
        run_frame(1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b1, lo);

        // Looping: second frame follows with no gap, then cansend drops before its end
        loop = 1'b1; cansend = 1'b1; start = 1'b1;
        tick();
        run_frame(1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0, lo);
        chk("loop_taken", 32'(frame_done), 1);
        run_frame(1'b0, 1'b1, 1'b0, 40, 1'b1, 1'b0, lo);
        start = 1'b1; cansend = 1'b0;
        repeat (4) begin
            tick();
            chk("nostart_busy", 32'(busy), 0);
        end

        // Randomized frames, idle gaps and input noise
        for (int it = 0; it < 6; it++) begin
            int gap;
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                start   = 1'($urandom % 2);
                cansend = start ? 1'b0 : 1'($urandom % 2);
                tick();
                chk("rgap_busy", 32'(busy), 0);
            end
            loop = 1'($urandom % 2);
            start = 1'b1; cansend = 1'b1;
            tick();
            nfr = 0;
            lo  = 1'b0;
            do begin
                run_frame(nfr == 0, lo, 1'b1, -1, nfr < 2, 1'b0, lo);
                nfr++;
            end while (lo);
            start = 1'b0; cansend = 1'b0;
        end

        // Asynchronous reset in slot (2,1)
        loop = 1'b0; start = 1'b1; cansend = 1'b1;
        tick();
        tick();
        for (int rel = 0; rel <= 16; rel++) begin
            check_model(rel, 1'b0, 1'b0);
            if (rel < 16) tick();
        end
        #2 RESET = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        start = 1'b0;
        repeat (3) tick();
        RESET = 1'b1;
        repeat (10) begin
            tick();
            chk("after_rst_busy", 32'(busy), 0);
            chk("after_rst_pixclk", 32'(pixclk), 0);
            chk("after_rst_h", 32'(H_Cont), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
